// File: rtl/mul_share_pkg.sv
// Shared types and defaults for the multiplier-sharing arbiter.
package mul_share_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int N_DEF       = 4;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef logic [$clog2(NUM_REQ_DEF)-1:0] req_id_t;
endpackage

// File: rtl/mul_share_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after ptr,
// wrapping modulo NUM_REQ. Produces a one-hot grant plus its encoded id.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     id,
  output logic               any
);
  int             s;
  logic [IDW-1:0] idx;

  always_comb begin
    gnt = '0;
    id  = '0;
    any = 1'b0;
    s   = 0;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s = int'(ptr) + i;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      idx = IDW'(s);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        id       = idx;
      end
    end
  end
endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one serial multiplier among NUM_REQ requesters,
// with a watchdog that turns a missing result into an error response.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int N       = N_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_vld,
  input  logic [NUM_REQ*16-1:0] req_a,
  input  logic [NUM_REQ*N-1:0]  req_b,
  output logic [NUM_REQ-1:0]    req_rdy,
  output logic [NUM_REQ-1:0]    rsp_vld,
  output logic [31:0]           rsp_c,
  output logic                  rsp_err,
  input  logic [NUM_REQ-1:0]    rsp_rdy,
  output logic                  mul_vld,
  output logic [15:0]           mul_a,
  output logic [N-1:0]          mul_b,
  input  logic [31:0]           mul_c,
  input  logic                  mul_result_vld,
  output logic                  spurious
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WDW = $clog2(TIMEOUT + 1);

  state_t               state_q, state_d;
  logic [IDW-1:0]       id_q, ptr_q;
  logic [15:0]          a_q;
  logic [N-1:0]         b_q;
  logic [31:0]          c_q;
  logic                 err_q;
  logic [WDW-1:0]       wd_q, wd_nxt;
  logic                 wd_expire;
  logic                 spurious_q;

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IDW-1:0]       pick_id;
  logic                 pick_any;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
    .req (req_vld),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .id  (pick_id),
    .any (pick_any)
  );

  assign wd_nxt    = wd_q + 1'b1;
  assign wd_expire = (wd_nxt == WDW'(TIMEOUT));
  assign spurious  = spurious_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Outputs are decoded from state so an async reset zeroes them at once;
  // req_rdy is additionally gated so it stays low while reset is held.
  always_comb begin
    state_d = state_q;
    req_rdy = '0;
    mul_vld = 1'b0;
    mul_a   = '0;
    mul_b   = '0;
    rsp_vld = '0;
    rsp_c   = '0;
    rsp_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any && rst_n) begin
          req_rdy = pick_gnt;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mul_vld = 1'b1;
        mul_a   = a_q;
        mul_b   = b_q;
        state_d = WAIT;
      end
      WAIT: begin
        mul_a = a_q;
        mul_b = b_q;
        if (mul_result_vld || wd_expire) state_d = RESP;
      end
      RESP: begin
        rsp_vld[id_q] = 1'b1;
        rsp_c         = c_q;
        rsp_err       = err_q;
        if (rsp_rdy[id_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q  <= '0;
      ptr_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      err_q <= 1'b0;
      wd_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (pick_any) begin
          id_q <= pick_id;
          a_q  <= req_a[pick_id*16 +: 16];
          b_q  <= req_b[pick_id*N +: N];
        end
        ISSUE: wd_q <= '0;
        WAIT: begin
          if (mul_result_vld) begin
            c_q   <= mul_c;
            err_q <= 1'b0;
          end else begin
            wd_q <= wd_nxt;
            if (wd_expire) begin
              c_q   <= '0;
              err_q <= 1'b1;
            end
          end
        end
        RESP: if (rsp_rdy[id_q])
          ptr_q <= (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        default: ;
      endcase
    end
  end

  // A result strobe outside WAIT has no owner; remember it until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    spurious_q <= 1'b0;
    else if (mul_result_vld && state_q != WAIT)    spurious_q <= 1'b1;
  end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a 2-cycle multiplier model.
module tb_mul_share_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_vld;
  logic [63:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_rdy;
  logic [3:0]  rsp_vld;
  logic [31:0] rsp_c;
  logic        rsp_err;
  logic [3:0]  rsp_rdy;
  logic        mul_vld;
  logic [15:0] mul_a;
  logic [3:0]  mul_b;
  logic [31:0] mul_c;
  logic        mul_result_vld;
  logic        spurious;

  logic        mul_en, inject;
  logic        s1, s2;
  logic [31:0] p1, p2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_share_arbiter #(.NUM_REQ(4), .N(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_a(req_a), .req_b(req_b), .req_rdy(req_rdy),
    .rsp_vld(rsp_vld), .rsp_c(rsp_c), .rsp_err(rsp_err), .rsp_rdy(rsp_rdy),
    .mul_vld(mul_vld), .mul_a(mul_a), .mul_b(mul_b),
    .mul_c(mul_c), .mul_result_vld(mul_result_vld), .spurious(spurious)
  );

  // Multiplier model: synchronous reset, result two cycles after mul_vld.
  always @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0; s2 <= 1'b0; p1 <= '0; p2 <= '0;
    end else begin
      s1 <= mul_vld & mul_en;
      p1 <= {16'b0, mul_a} * {28'b0, mul_b};
      s2 <= s1;
      p2 <= p1;
    end
  end
  assign mul_result_vld = s2 | inject;
  assign mul_c          = p2;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic check_zero(input string nm);
    check({nm, " req_rdy"}, {28'b0, req_rdy}, 0);
    check({nm, " rsp_vld"}, {28'b0, rsp_vld}, 0);
    check({nm, " rsp_c"}, rsp_c, 0);
    check({nm, " rsp_err"}, {31'b0, rsp_err}, 0);
    check({nm, " mul_vld"}, {31'b0, mul_vld}, 0);
    check({nm, " mul_a"}, {16'b0, mul_a}, 0);
    check({nm, " mul_b"}, {28'b0, mul_b}, 0);
    check({nm, " spurious"}, {31'b0, spurious}, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge with the DUT in IDLE; returns at the negedge of T+5.
  task automatic run_op(input string nm, input logic [3:0] mask, input int id,
                        input logic [15:0] a, input logic [3:0] b, input logic [31:0] exp_c);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    req_a[id*16 +: 16] = a;
    req_b[id*4 +: 4]   = b;
    req_vld = mask | oh;
    #1 check({nm, " req_rdy"}, {28'b0, req_rdy}, {28'b0, oh});
    @(negedge clk);
    req_vld[id] = 1'b0;
    check({nm, " mul_vld"}, {31'b0, mul_vld}, 1);
    check({nm, " mul_a"}, {16'b0, mul_a}, {16'b0, a});
    check({nm, " mul_b"}, {28'b0, mul_b}, {28'b0, b});
    @(negedge clk);
    check({nm, " mul_vld_pulse"}, {31'b0, mul_vld}, 0);
    @(negedge clk);
    @(negedge clk);
    check({nm, " rsp_vld"}, {28'b0, rsp_vld}, {28'b0, oh});
    check({nm, " rsp_c"}, rsp_c, exp_c);
    check({nm, " rsp_err"}, {31'b0, rsp_err}, 0);
    @(negedge clk);
  endtask

  typedef struct {
    string       nm;
    int          id;
    logic [15:0] a;
    logic [3:0]  b;
    logic [31:0] exp_c;
  } vec_t;

  vec_t vecs[4];
  logic [31:0] prod4[4];

  initial begin
    vecs[0] = '{"single", 2, 16'h0003, 4'h5, 32'd15};
    vecs[1] = '{"zero_b", 1, 16'hFFFF, 4'h0, 32'd0};
    vecs[2] = '{"max_ops", 0, 16'hFFFF, 4'hF, 32'h000E_FFF1};
    vecs[3] = '{"mid", 3, 16'h1234, 4'h2, 32'h0000_2468};
    prod4   = '{32'd10, 32'd22, 32'd36, 32'd52};

    rst_n = 1'b0; req_vld = '0; req_a = '0; req_b = '0; rsp_rdy = 4'hF;
    mul_en = 1'b1; inject = 1'b0;
    #3 check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].nm, 4'b0000, vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp_c);

    // All four requesting from reset: grants 0,1,2,3 at 5-cycle spacing.
    do_reset();
    req_a   = {16'd13, 16'd12, 16'd11, 16'd10};
    req_b   = {4'd4, 4'd3, 4'd2, 4'd1};
    req_vld = 4'hF;
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("rr%0d req_rdy", k), {28'b0, req_rdy}, 32'd1 << k);
      @(negedge clk);
      req_vld[k] = 1'b0;
      check($sformatf("rr%0d req_rdy_busy", k), {28'b0, req_rdy}, 0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check($sformatf("rr%0d rsp_vld", k), {28'b0, rsp_vld}, 32'd1 << k);
      check($sformatf("rr%0d rsp_c", k), rsp_c, prod4[k]);
      @(negedge clk);
    end

    // Pointer wrapped to 0: with 0 and 3 requesting, 0 wins, then 3.
    run_op("reassert0", 4'b1001, 0, 16'd6, 4'd7, 32'd42);
    run_op("reassert3", 4'b0000, 3, 16'd8, 4'd8, 32'd64);

    // Back-pressure on requester 1 while requester 0 waits.
    req_a[16 +: 16] = 16'd100; req_b[4 +: 4] = 4'd11;
    req_vld = 4'b0010;
    rsp_rdy = 4'b1101;
    #1 check("bp req_rdy", {28'b0, req_rdy}, 32'b0010);
    @(negedge clk);
    req_a[0 +: 16] = 16'd7; req_b[0 +: 4] = 4'd9;
    req_vld = 4'b0001;
    check("bp busy req_rdy", {28'b0, req_rdy}, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("bp%0d rsp_vld", i), {28'b0, rsp_vld}, 32'b0010);
      check($sformatf("bp%0d rsp_c", i), rsp_c, 32'd1100);
      check($sformatf("bp%0d req_rdy", i), {28'b0, req_rdy}, 0);
      @(negedge clk);
    end
    rsp_rdy = 4'hF;
    #1 check("bp hs rsp_vld", {28'b0, rsp_vld}, 32'b0010);
    @(negedge clk);
    check("bp next req_rdy", {28'b0, req_rdy}, 32'b0001);
    @(negedge clk);
    req_vld = '0;
    check("bp next mul_a", {16'b0, mul_a}, 32'd7);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("bp next rsp_vld", {28'b0, rsp_vld}, 32'b0001);
    check("bp next rsp_c", rsp_c, 32'd63);
    @(negedge clk);

    // Timeout: multiplier never answers.
    mul_en = 1'b0;
    req_a[32 +: 16] = 16'd5; req_b[8 +: 4] = 4'd5;
    req_vld = 4'b0100;
    #1 check("to req_rdy", {28'b0, req_rdy}, 32'b0100);
    @(negedge clk);
    req_vld = '0;
    repeat (15) @(negedge clk);
    check("to early rsp_vld", {28'b0, rsp_vld}, 0);
    check("to held mul_a", {16'b0, mul_a}, 32'd5);
    @(negedge clk);
    check("to rsp_vld", {28'b0, rsp_vld}, 32'b0100);
    check("to rsp_err", {31'b0, rsp_err}, 1);
    check("to rsp_c", rsp_c, 0);
    @(negedge clk);
    check("to spurious_clear", {31'b0, spurious}, 0);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    check("to spurious_set", {31'b0, spurious}, 1);
    mul_en = 1'b1;

    // Reset mid-WAIT, then pointer must be back at 0 (grant 1 over 3).
    req_a[48 +: 16] = 16'd2; req_b[12 +: 4] = 4'd3;
    req_vld = 4'b1000;
    #1 check("rw req_rdy", {28'b0, req_rdy}, 32'b1000);
    @(negedge clk);
    req_vld = '0;
    @(negedge clk);
    check("rw in_wait mul_a", {16'b0, mul_a}, 32'd2);
    rst_n = 1'b0;
    #1 check_zero("rw async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 4'b1000, 1, 16'd9, 4'd9, 32'd81);
    req_vld = '0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end
endmodule
